data_memory_arbiter: RTL
========================

// Module: data_memory_arbiter
// PURPOSE
//  Shares the single-port data_memory between two requesters: port 0 (CPU load/store
//  path, priority) and port 1 (loader/debug path). Registered req/ready handshake per
//  port, priority arbitration with starvation guard. Drives data_memory
//  mem_write/mem_read/address/write_data and captures read_data.
// PARAMETERS
//  ADDR_WIDTH    64  address width, all ports
//  DATA_WIDTH    64  data width, all ports
//  STARVE_LIMIT  4   consecutive p0 grants while p1 waits before p1 is forced; range 1..15
// PORTS
//  clock       in   1           system clock, rising edge
//  reset       in   1           synchronous, active-high
//  p0_req      in   1           port 0 access request; held until p0_ready
//  p0_we       in   1           1 = write, 0 = read; stable while p0_req
//  p0_addr     in   ADDR_WIDTH  port 0 address; stable while p0_req
//  p0_wdata    in   DATA_WIDTH  port 0 write data; stable while p0_req
//  p0_ready    out  1           1-cycle pulse: port 0 access complete
//  p0_rvalid   out  1           1-cycle pulse with p0_ready on reads only
//  p0_rdata    out  DATA_WIDTH  read result; valid when p0_rvalid, held otherwise
//  p1_*        --   --          identical set for port 1
//  mem_write   out  1           to data_memory
//  mem_read    out  1           to data_memory
//  address     out  ADDR_WIDTH  to data_memory
//  write_data  out  DATA_WIDTH  to data_memory
//  read_data   in   DATA_WIDTH  from data_memory (combinational read)
//  busy        out  1           high in ACCESS and DONE
// BEHAVIOUR
//  - All outputs registered. Reset: FSM=IDLE, starve_cnt=0, every output 0 (incl. rdata).
//  - FSM: IDLE -> ACCESS -> DONE -> IDLE. No other transitions except reset -> IDLE.
//  - IDLE: if any req, pick winner, latch winner's we/addr/wdata into mem_* regs, go ACCESS.
//    No req: stay IDLE, mem_write=mem_read=0, address=write_data=0.
//  - Arbitration: only p0 -> p0; only p1 -> p1; both -> p0 unless starve_cnt==STARVE_LIMIT,
//    then p1.
//  - starve_cnt: +1 on each p0 grant while p1_req=1; cleared on p1 grant or when
//    p1_req=0 in IDLE; saturates at STARVE_LIMIT.
//  - ACCESS (1 cycle): exactly one of mem_write/mem_read high, never both. Write commits
//    in data_memory at the edge ending ACCESS; read_data sampled into winner's rdata there.
//  - DONE (1 cycle): winner's ready=1; rvalid=1 iff read; mem_* cleared; all reqs ignored
//    (requester drops req this cycle). Next grant is evaluated in the following IDLE.
//  - Latency: req seen in IDLE at cycle N -> ready at cycle N+2. Throughput: 1 access per
//    3 cycles. Loser's req stays pending, no timeout.
//  - Address/data passed unchanged; no alignment check or width conversion.
//  - Requester changing we/addr/wdata before ready: undefined; the latched IDLE value is
//    used.
//  - Reset during ACCESS: the write still commits (memory samples mem_write at that edge;
//    memory has no reset); no ready/rvalid issued; FSM -> IDLE; rdata cleared.
//  - Reset during DONE: ready pulse is truncated; outputs 0 next cycle.
// TESTING
//  1. Hold reset 2 cycles -> all outputs 0, busy=0; release, no req -> mem_* stay 0.
//  2. p0 write addr 0 = AAAA_BBBB_CCCC_DDDD, then p0 read addr 0 -> p0_ready at N+2,
//     p0_rvalid=1, p0_rdata = AAAA_BBBB_CCCC_DDDD; write ready has p0_rvalid=0.
//  3. Same cycle: p0 write addr 4 = 1234_5678_9ABC_DEF0, p1 read addr 4 -> p0 served
//     first; p1_ready 3 cycles later with p1_rdata = 1234_5678_9ABC_DEF0.
//  4. p0 re-requests continuously, p1 read held (STARVE_LIMIT=4) -> exactly 4 p0 grants,
//     then p1 granted, starve_cnt=0, then p0 resumes.
//  5. p1 write addr 8 = DEAD_BEEF_0000_1111, reset asserted in ACCESS -> no p1_ready,
//     FSM IDLE; later p0 read addr 8 returns DEAD_BEEF_0000_1111.
//  6. Protocol checks all runs: mem_write&mem_read never both 1; one ready per grant;
//     rvalid only with ready on reads.

Source files
------------

// File: rtl/data_memory_arbiter_if.sv
// One requester port of data_memory_arbiter: req/ready handshake, access payload
// and read return. The requester uses the master modport and the arbiter uses the slave modport.
interface data_memory_arbiter_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) ();
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ready;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output req, we, addr, wdata, input ready, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/data_memory_arbiter.sv
// Two-port arbiter in front of the single-port data_memory. Port 0 has priority, and a
// starvation guard forces port 1 through after STARVE_LIMIT consecutive port-0 grants.
module data_memory_arbiter #(
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    data_memory_arbiter_if.slave  p0,
    data_memory_arbiter_if.slave  p1,
    output logic                  mem_write,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic                  busy
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t                state_q, state_d;
    logic [3:0]            starve_q, starve_d;
    logic                  owner_q, owner_d;

    logic                  any_req;
    logic                  grant_p1;
    logic                  win_we;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;

    logic                  mem_write_d, mem_read_d, busy_d;
    logic [ADDR_WIDTH-1:0] address_d;
    logic [DATA_WIDTH-1:0] write_data_d;
    logic [1:0]            ready_d, ready_q;
    logic [1:0]            rvalid_d, rvalid_q;
    logic [DATA_WIDTH-1:0] p0_rdata_d, p0_rdata_q;
    logic [DATA_WIDTH-1:0] p1_rdata_d, p1_rdata_q;

    assign any_req   = p0.req | p1.req;
    // Port 1 also wins a tie once port 0 has taken STARVE_LIMIT grants in a row over it.
    assign grant_p1  = p1.req & (~p0.req | (starve_q == STARVE_MAX));
    assign win_we    = grant_p1 ? p1.we    : p0.we;
    assign win_addr  = grant_p1 ? p1.addr  : p0.addr;
    assign win_wdata = grant_p1 ? p1.wdata : p0.wdata;

    // NOTE: non-blocking assignments make every flop sample pre-edge values, so the order of statements cannot change behaviour.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            starve_q <= '0;
            owner_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            owner_q  <= owner_d;
        end
    end

    always_comb begin
        // NOTE: defaults come first, so every path assigns every variable and no latch is inferred.
        state_d  = state_q;
        starve_d = starve_q;
        owner_d  = owner_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ACCESS;
                    owner_d = grant_p1;
                end
                if (!p1.req || grant_p1) begin
                    starve_d = '0;
                end else if (starve_q != STARVE_MAX) begin
                    starve_d = starve_q + 4'd1;
                end
            end
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs. During ACCESS, mem_read is already the latched direction.
    always_comb begin
        mem_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        address_d    = '0;
        write_data_d = '0;
        busy_d       = 1'b0;
        ready_d      = '0;
        rvalid_d     = '0;
        p0_rdata_d   = p0_rdata_q;
        p1_rdata_d   = p1_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    mem_write_d  = win_we;
                    mem_read_d   = ~win_we;
                    address_d    = win_addr;
                    write_data_d = win_wdata;
                    busy_d       = 1'b1;
                end
            end
            ACCESS: begin
                busy_d            = 1'b1;
                ready_d[owner_q]  = 1'b1;
                rvalid_d[owner_q] = mem_read;
                if (mem_read) begin
                    if (owner_q) p1_rdata_d = read_data;
                    else         p0_rdata_d = read_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_write  <= 1'b0;
            mem_read   <= 1'b0;
            address    <= '0;
            write_data <= '0;
            busy       <= 1'b0;
            ready_q    <= '0;
            rvalid_q   <= '0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            mem_write  <= mem_write_d;
            mem_read   <= mem_read_d;
            address    <= address_d;
            write_data <= write_data_d;
            busy       <= busy_d;
            ready_q    <= ready_d;
            rvalid_q   <= rvalid_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
        end
    end

    assign p0.ready  = ready_q[0];
    assign p0.rvalid = rvalid_q[0];
    assign p0.rdata  = p0_rdata_q;
    assign p1.ready  = ready_q[1];
    assign p1.rvalid = rvalid_q[1];
    assign p1.rdata  = p1_rdata_q;
endmodule
